acc_req_arbiter: RTL and testbench

Shares one accelerator adapter port between `NumReq` requesting cores on the accelerator bus. Requests are arbitrated round-robin into a one-entry output register, and each request ID is extended with the requester index. Responses are routed back to the issuing requester by that index. Per-requester credit counters bound the number of outstanding requests. The block sits between the core-side request ports and one slave port of the accelerator interconnect.

---
 rtl/acc_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_acc_req_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter that shares one accelerator request port between NumReq cores,
// tags each request with the requester index and routes responses back by that index.
module acc_req_arbiter #(
  parameter int NumReq         = 4,
  parameter int IdWidth        = 1,
  parameter int ReqWidth       = 105,
  parameter int RspWidth       = 66,
  parameter int MaxOutstanding = 4,
  localparam int IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int ExtIdWidth    = IdxWidth + IdWidth,
  localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_n,
  input  logic [NumReq-1:0]                  slv_q_valid_i,
  output logic [NumReq-1:0]                  slv_q_ready_o,
  input  logic [NumReq-1:0][IdWidth-1:0]     slv_q_id_i,
  input  logic [NumReq-1:0][ReqWidth-1:0]    slv_q_data_i,
  output logic                               mst_q_valid_o,
  input  logic                               mst_q_ready_i,
  output logic [ExtIdWidth-1:0]              mst_q_id_o,
  output logic [ReqWidth-1:0]                mst_q_data_o,
  input  logic                               mst_p_valid_i,
  output logic                               mst_p_ready_o,
  input  logic [ExtIdWidth-1:0]              mst_p_id_i,
  input  logic [RspWidth-1:0]                mst_p_data_i,
  output logic [NumReq-1:0]                  slv_p_valid_o,
  input  logic [NumReq-1:0]                  slv_p_ready_i,
  output logic [IdWidth-1:0]                 slv_p_id_o,
  output logic [RspWidth-1:0]                slv_p_data_o,
  output logic [NumReq-1:0][CntWidth-1:0]    outstanding_o,
  output logic                               err_o
);

  localparam int IdxRange = 2 ** IdxWidth;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic                           full;
  logic [ExtIdWidth-1:0]          q_id;
  logic [ReqWidth-1:0]            q_data;
  logic [IdxWidth-1:0]            rr_ptr;
  logic [NumReq-1:0][CntWidth-1:0] cnt;
  logic                           err;

  logic [NumReq-1:0]   eligible;
  logic [NumReq-1:0]   inc;
  logic [NumReq-1:0]   dec;
  logic                load;
  logic                gnt_valid;
  logic [IdxWidth-1:0] gnt_idx;

  logic [IdxWidth-1:0] p_idx;
  logic [IdxRange-1:0] cnt_nz;
  logic [IdxRange-1:0] ready_pad;
  logic                rsp_ok;
  logic                sel_ready;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = slv_q_valid_i[i] && (cnt[i] < MaxCnt);
    end
  end

  assign load = !full || mst_q_ready_i;

  // Scan from the farthest candidate back to rr_ptr so the nearest eligible one wins.
  always_comb begin
    logic [IdxWidth:0] cand;
    cand      = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IdxWidth + 1)'(k);
      if (cand >= (IdxWidth + 1)'(NumReq)) begin
        cand = cand - (IdxWidth + 1)'(NumReq);
      end
      if (eligible[cand[IdxWidth-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IdxWidth-1:0];
      end
    end
    gnt_valid = gnt_valid && load && !rst_n;
  end

  always_comb begin
    inc = '0;
    if (gnt_valid) begin
      inc[gnt_idx] = 1'b1;
    end
  end

  assign slv_q_ready_o = inc;

  // Padding to a power of two makes out-of-range indices read as "no credit".
  always_comb begin
    cnt_nz    = '0;
    ready_pad = '0;
    for (int i = 0; i < NumReq; i++) begin
      cnt_nz[i]    = |cnt[i];
      ready_pad[i] = slv_p_ready_i[i];
    end
  end

  assign p_idx     = mst_p_id_i[ExtIdWidth-1 -: IdxWidth];
  assign rsp_ok    = cnt_nz[p_idx];
  assign sel_ready = ready_pad[p_idx];

  always_comb begin
    slv_p_valid_o = '0;
    dec           = '0;
    mst_p_ready_o = 1'b0;
    if (!rst_n) begin
      mst_p_ready_o = rsp_ok ? sel_ready : 1'b1;
      for (int i = 0; i < NumReq; i++) begin
        if (rsp_ok && (p_idx == IdxWidth'(i))) begin
          slv_p_valid_o[i] = mst_p_valid_i;
          dec[i]           = mst_p_valid_i && sel_ready;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      full   <= 1'b0;
      q_id   <= '0;
      q_data <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (load) begin
        full <= gnt_valid;
      end
      if (gnt_valid) begin
        q_id   <= {gnt_idx, slv_q_id_i[gnt_idx]};
        q_data <= slv_q_data_i[gnt_idx];
        rr_ptr <= (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + IdxWidth'(1);
      end
      for (int i = 0; i < NumReq; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CntWidth'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - CntWidth'(1);
        end
      end
      if (mst_p_valid_i && !rsp_ok) begin
        err <= 1'b1;
      end
    end
  end

  assign mst_q_valid_o = full;
  assign mst_q_id_o    = q_id;
  assign mst_q_data_o  = q_data;
  assign slv_p_id_o    = mst_p_id_i[IdWidth-1:0];
  assign slv_p_data_o  = mst_p_data_i;
  assign outstanding_o = cnt;
  assign err_o         = err;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Self-checking bench for acc_req_arbiter: directed scenarios pinned with literal values,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_acc_req_arbiter;

  localparam int NUM = 4;
  localparam int IW  = 1;
  localparam int RW  = 105;
  localparam int PW  = 66;
  localparam int MAX = 4;
  localparam int XW  = 3;
  localparam int CW  = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM-1:0]           vq;
  logic [NUM-1:0]           qready;
  logic [NUM-1:0][IW-1:0]   qid;
  logic [NUM-1:0][RW-1:0]   qdata;
  logic                     mq_valid;
  logic                     mq_ready;
  logic [XW-1:0]            mq_id;
  logic [RW-1:0]            mq_data;
  logic                     pv;
  logic                     pready;
  logic [XW-1:0]            pid;
  logic [PW-1:0]            pdata;
  logic [NUM-1:0]           spvalid;
  logic [NUM-1:0]           sready;
  logic [IW-1:0]            spid;
  logic [PW-1:0]            spdata;
  logic [NUM-1:0][CW-1:0]   outstanding;
  logic                     err;

  int checks = 0;
  int errors = 0;

  // transaction-level model state
  int             mcnt[NUM];
  bit             mfull;
  logic [XW-1:0]  mid;
  logic [RW-1:0]  mdata;
  int             mrr;
  bit             merr;
  logic [XW-1:0]  inflight[$];
  bit             rsp_hold;

  // per-cycle expectations
  int             eg;
  int             e_pidx;
  bit             e_ok;
  logic [NUM-1:0] e_qready;
  logic           e_pready;
  logic [NUM-1:0] e_pvalid;

  logic [RW-1:0]  d1;
  logic [RW-1:0]  d2;

  acc_req_arbiter #(
    .NumReq(NUM), .IdWidth(IW), .ReqWidth(RW), .RspWidth(PW), .MaxOutstanding(MAX)
  ) dut (
    .clk_i(clk),
    .rst_n(rst_n),
    .slv_q_valid_i(vq),
    .slv_q_ready_o(qready),
    .slv_q_id_i(qid),
    .slv_q_data_i(qdata),
    .mst_q_valid_o(mq_valid),
    .mst_q_ready_i(mq_ready),
    .mst_q_id_o(mq_id),
    .mst_q_data_o(mq_data),
    .mst_p_valid_i(pv),
    .mst_p_ready_o(pready),
    .mst_p_id_i(pid),
    .mst_p_data_i(pdata),
    .slv_p_valid_o(spvalid),
    .slv_p_ready_i(sready),
    .slv_p_id_o(spid),
    .slv_p_data_o(spdata),
    .outstanding_o(outstanding),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic expectEq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM; i++) mcnt[i] = 0;
    mfull = 0;
    mid = '0;
    mdata = '0;
    mrr = 0;
    merr = 0;
    inflight.delete();
    rsp_hold = 0;
  endtask

  task automatic clearInputs();
    vq = '0;
    qid = '0;
    qdata = '0;
    mq_ready = 1'b0;
    pv = 1'b0;
    pid = '0;
    pdata = '0;
    sready = '0;
  endtask

  // Grant and response routing derived directly from the arbitration rules.
  task automatic computeExpected();
    int j;
    eg = -1;
    if (!mfull || mq_ready) begin
      for (int k = 0; k < NUM; k++) begin
        j = (mrr + k) % NUM;
        if (eg < 0 && vq[j] && mcnt[j] < MAX) eg = j;
      end
    end
    e_qready = (eg >= 0) ? NUM'(1 << eg) : '0;
    e_pidx   = int'(pid) >> IW;
    e_ok     = (e_pidx < NUM) && (mcnt[e_pidx] > 0);
    e_pready = e_ok ? sready[e_pidx] : 1'b1;
    e_pvalid = (e_ok && pv) ? NUM'(1 << e_pidx) : '0;
  endtask

  task automatic checkOutput();
    computeExpected();
    expectEq("slv_q_ready", qready, e_qready);
    expectEq("mst_q_valid", mq_valid, mfull);
    expectEq("mst_q_id", mq_id, mid);
    expectEq("mst_q_data", mq_data, mdata);
    expectEq("mst_p_ready", pready, e_pready);
    expectEq("slv_p_valid", spvalid, e_pvalid);
    expectEq("slv_p_id", spid, pid[IW-1:0]);
    expectEq("slv_p_data", spdata, pdata);
    for (int i = 0; i < NUM; i++) expectEq($sformatf("outstanding[%0d]", i), outstanding[i], mcnt[i]);
    expectEq("err", err, merr);
  endtask

  task automatic updateModel();
    bit hs;
    computeExpected();
    hs = pv && e_pready;
    if (mfull && mq_ready) begin
      inflight.push_back(mid);
      mfull = 0;
    end
    if (hs) begin
      if (e_ok) begin
        mcnt[e_pidx]--;
        for (int i = 0; i < inflight.size(); i++) begin
          if (inflight[i] == pid) begin
            inflight.delete(i);
            break;
          end
        end
      end else begin
        merr = 1;
      end
    end
    if (eg >= 0) begin
      mcnt[eg]++;
      mfull = 1;
      mid   = {2'(eg), qid[eg]};
      mdata = qdata[eg];
      mrr   = (eg + 1) % NUM;
    end
    rsp_hold = pv && !hs;
  endtask

  task automatic settle();
    #1;
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b1;
    clearInputs();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [127:0] r;
    int start;
    int j;
    vq = NUM'($urandom);
    for (int i = 0; i < NUM; i++) begin
      qid[i] = IW'($urandom);
      r = {$urandom, $urandom, $urandom, $urandom};
      qdata[i] = r[RW-1:0];
    end
    mq_ready = ($urandom_range(0, 3) != 0);
    sready = NUM'($urandom);
    r = {$urandom, $urandom, $urandom, $urandom};
    pdata = r[PW-1:0];
    if (!rsp_hold) begin
      pv = 1'b0;
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        pv  = 1'b1;
        pid = inflight[$urandom_range(0, inflight.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        start = $urandom_range(0, NUM - 1);
        for (int k = 0; k < NUM; k++) begin
          j = (start + k) % NUM;
          if (!pv && mcnt[j] == 0) begin
            pv  = 1'b1;
            pid = {2'(j), IW'($urandom)};
          end
        end
      end
    end
  endtask

  logic [NUM-1:0] rr_grant[5];
  logic [XW-1:0]  rr_id[5];

  initial begin
    rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id    = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b110};
    clearInputs();
    modelReset();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // reset state with live inputs on every port
    vq = '1; pv = 1'b1; sready = '1; mq_ready = 1'b1;
    #1;
    expectEq("reset_slv_q_ready", qready, 4'b0000);
    expectEq("reset_mst_p_ready", pready, 1'b0);
    expectEq("reset_slv_p_valid", spvalid, 4'b0000);
    expectEq("reset_mst_q_valid", mq_valid, 1'b0);
    expectEq("reset_mst_q_id", mq_id, 3'b000);
    expectEq("reset_outstanding", outstanding, 12'h000);
    expectEq("reset_err", err, 1'b0);
    rst_n = 1'b0;
    clearInputs();

    // round-robin rotation with every requester valid
    vq = '1; mq_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      expectEq("rr_grant", qready, rr_grant[c]);
      if (c > 0) expectEq("rr_mst_q_id", mq_id, rr_id[c]);
      advance();
    end
    doReset();

    // backpressure on a single requester
    d1 = {41'h1_2345_6789, 64'hDEAD_BEEF_CAFE_F00D};
    d2 = {41'h0_0F0F_0F0F, 64'h0123_4567_89AB_CDEF};
    vq = 4'b0100; qid[2] = 1'b1; qdata[2] = d1; mq_ready = 1'b0;
    settle();
    expectEq("bp_first_grant", qready, 4'b0100);
    advance();
    qdata[2] = d2;
    for (int c = 0; c < 5; c++) begin
      settle();
      expectEq("bp_valid_held", mq_valid, 1'b1);
      expectEq("bp_id_held", mq_id, 3'b101);
      expectEq("bp_data_held", mq_data, d1);
      expectEq("bp_ready_low", qready, 4'b0000);
      advance();
    end
    mq_ready = 1'b1;
    settle();
    expectEq("bp_drain_grant", qready, 4'b0100);
    advance();
    settle();
    expectEq("bp_next_data", mq_data, d2);
    advance();
    doReset();

    // credit limit on requester 1
    vq = 4'b0010; mq_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      expectEq("credit_ready", qready[1], (c < 4) ? 1'b1 : 1'b0);
      advance();
    end
    settle();
    expectEq("credit_full_count", outstanding[1], 3'd4);
    pv = 1'b1; pid = 3'b010; sready = 4'b0010;
    settle();
    expectEq("credit_rsp_ready", pready, 1'b1);
    expectEq("credit_rsp_valid", spvalid, 4'b0010);
    advance();
    pv = 1'b0;
    settle();
    expectEq("credit_fifth_grant", qready, 4'b0010);
    advance();
    settle();
    expectEq("credit_refilled", outstanding[1], 3'd4);
    advance();
    doReset();

    // response routing with requester-side backpressure
    vq = 4'b1000; qid[3] = 1'b1; mq_ready = 1'b1;
    settle(); advance();
    vq = '0;
    settle(); advance();
    pv = 1'b1; pid = 3'b111; sready = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      settle();
      expectEq("route_valid", spvalid, 4'b1000);
      expectEq("route_id", spid, 1'b1);
      expectEq("route_ready_low", pready, 1'b0);
      advance();
    end
    sready = 4'b1000;
    settle();
    expectEq("route_ready_high", pready, 1'b1);
    advance();
    pv = 1'b0;
    settle();
    expectEq("route_count_dec", outstanding[3], 3'd0);
    advance();

    // same-cycle grant and response for requester 0
    vq = 4'b0001; qid[0] = 1'b0;
    settle(); advance();
    vq = '0;
    settle(); advance();
    vq = 4'b0001; pv = 1'b1; pid = 3'b000; sready = 4'b0001;
    settle();
    expectEq("simul_grant", qready, 4'b0001);
    expectEq("simul_rsp_ready", pready, 1'b1);
    advance();
    vq = '0; pv = 1'b0;
    settle();
    expectEq("simul_count_same", outstanding[0], 3'd1);
    advance();
    doReset();

    // response without a credit is sunk and flagged
    pv = 1'b1; pid = 3'b000; sready = '1;
    settle();
    expectEq("err_sunk_ready", pready, 1'b1);
    expectEq("err_no_valid", spvalid, 4'b0000);
    advance();
    pv = 1'b0;
    settle();
    expectEq("err_set", err, 1'b1);
    for (int c = 0; c < 3; c++) advance();
    settle();
    expectEq("err_sticky", err, 1'b1);
    advance();
    doReset();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      settle();
      advance();
    end

    // asynchronous reset in the middle of a burst
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      vq = '1;
      settle();
      advance();
    end
    applyStimulus();
    settle();
    #2;
    rst_n = 1'b1;
    #1;
    expectEq("midrst_mst_q_valid", mq_valid, 1'b0);
    expectEq("midrst_mst_q_id", mq_id, 3'b000);
    expectEq("midrst_mst_q_data", mq_data, '0);
    expectEq("midrst_slv_q_ready", qready, 4'b0000);
    expectEq("midrst_slv_p_valid", spvalid, 4'b0000);
    expectEq("midrst_mst_p_ready", pready, 1'b0);
    expectEq("midrst_outstanding", outstanding, 12'h000);
    expectEq("midrst_err", err, 1'b0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    clearInputs();
    rst_n = 1'b0;
    pv = 1'b1; pid = 3'b000; sready = '1;
    settle();
    expectEq("stale_rsp_sunk", pready, 1'b1);
    advance();
    pv = 1'b0;
    settle();
    expectEq("stale_rsp_err", err, 1'b1);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
